// File: rtl/st_pop_sequencer.sv
// Multi-cycle POP {RL} sequencer: reads one stacked word per listed register,
// writes it to the register file (R0..R7) or PC, then commits the advanced SP.
module st_pop_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [8:0]        rl,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              busy,
    output logic              done,
    output logic              dmem_rd,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              rf_wr,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_wr,
    output logic [15:0]       pc_wdata,
    output logic              sp_wr,
    output logic [ADDR_W-1:0] sp_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
    localparam logic [3:0] PC_IDX = 4'd8;

    state_t            state;
    logic [8:0]        mask;
    logic [ADDR_W-1:0] sp_cur;
    logic [3:0]        idx;
    logic [CNT_W-1:0]  wait_cnt;

    logic [8:0]        src_mask;
    logic [3:0]        next_idx;
    logic [8:0]        next_mask;
    logic [ADDR_W-1:0] sp_next;

    function automatic logic [3:0] lowest_bit(input logic [8:0] m);
        logic [3:0] lo;
        lo = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i]) lo = 4'(i);
        end
        return lo;
    endfunction

    // Next register to pop: from the incoming list when idle, else from what remains.
    always_comb begin
        src_mask  = (state == S_IDLE) ? rl : mask;
        next_idx  = lowest_bit(src_mask);
        next_mask = src_mask & ~(9'b1 << next_idx);
        sp_next   = sp_cur + ADDR_W'(1);
    end

    // Read data is only valid in the WRITE cycle, so the data paths are gated, not registered.
    assign rf_wdata = rf_wr ? dmem_rdata : '0;
    assign pc_wdata = pc_wr ? dmem_rdata[15:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mask      <= '0;
            sp_cur    <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dmem_rd   <= 1'b0;
            dmem_addr <= '0;
            rf_wr     <= 1'b0;
            rf_waddr  <= '0;
            pc_wr     <= 1'b0;
            sp_wr     <= 1'b0;
            sp_out    <= '0;
        end else begin
            dmem_rd   <= 1'b0;
            dmem_addr <= '0;
            rf_wr     <= 1'b0;
            rf_waddr  <= '0;
            pc_wr     <= 1'b0;
            done      <= 1'b0;
            sp_wr     <= 1'b0;
            sp_out    <= '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        sp_cur <= sp_in;
                        busy   <= 1'b1;
                        if (rl != 9'd0) begin
                            state     <= S_ISSUE;
                            idx       <= next_idx;
                            mask      <= next_mask;
                            dmem_rd   <= 1'b1;
                            dmem_addr <= sp_in;
                        end else begin
                            // Empty list: complete without touching memory or SP.
                            state  <= S_FINISH;
                            mask   <= '0;
                            done   <= 1'b1;
                            sp_out <= sp_in;
                        end
                    end
                end

                S_ISSUE: begin
                    if (MEM_LAT == 1) begin
                        state    <= S_WRITE;
                        rf_wr    <= (idx != PC_IDX);
                        rf_waddr <= (idx != PC_IDX) ? idx[2:0] : 3'd0;
                        pc_wr    <= (idx == PC_IDX);
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= S_WRITE;
                        rf_wr    <= (idx != PC_IDX);
                        rf_waddr <= (idx != PC_IDX) ? idx[2:0] : 3'd0;
                        pc_wr    <= (idx == PC_IDX);
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    sp_cur <= sp_next;
                    if (mask != 9'd0) begin
                        state     <= S_ISSUE;
                        idx       <= next_idx;
                        mask      <= next_mask;
                        dmem_rd   <= 1'b1;
                        dmem_addr <= sp_next;
                    end else begin
                        state  <= S_FINISH;
                        done   <= 1'b1;
                        sp_wr  <= 1'b1;
                        sp_out <= sp_next;
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_st_pop_sequencer.sv
// Bench for st_pop_sequencer: two instances (MEM_LAT=1 and 3) run the same POPs and are
// compared cycle by cycle against a schedule computed from the register list.
module tb_st_pop_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  rl_i;
    logic [15:0] sp_i;

    logic [31:0] mem [0:65535];

    logic [31:0] rdata1, rdata3;
    logic        o1_busy, o1_done, o1_rd, o1_rfw, o1_pcw, o1_spw;
    logic [15:0] o1_addr, o1_pcd, o1_spo;
    logic [2:0]  o1_wa;
    logic [31:0] o1_wd;
    logic        o3_busy, o3_done, o3_rd, o3_rfw, o3_pcw, o3_spw;
    logic [15:0] o3_addr, o3_pcd, o3_spo;
    logic [2:0]  o3_wa;
    logic [31:0] o3_wd;

    int errors = 0;
    int checks = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    st_pop_sequencer #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .rl(rl_i), .sp_in(sp_i),
        .dmem_rdata(rdata1), .busy(o1_busy), .done(o1_done), .dmem_rd(o1_rd),
        .dmem_addr(o1_addr), .rf_wr(o1_rfw), .rf_waddr(o1_wa), .rf_wdata(o1_wd),
        .pc_wr(o1_pcw), .pc_wdata(o1_pcd), .sp_wr(o1_spw), .sp_out(o1_spo)
    );

    st_pop_sequencer #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .rl(rl_i), .sp_in(sp_i),
        .dmem_rdata(rdata3), .busy(o3_busy), .done(o3_done), .dmem_rd(o3_rd),
        .dmem_addr(o3_addr), .rf_wr(o3_rfw), .rf_waddr(o3_wa), .rf_wdata(o3_wd),
        .pc_wr(o3_pcw), .pc_wdata(o3_pcd), .sp_wr(o3_spw), .sp_out(o3_spo)
    );

    // memory models: data for an address appears MEM_LAT cycles after it is presented
    logic [15:0] ap1;
    logic [15:0] ap3 [3];
    always @(posedge clk) begin
        ap1    <= o1_addr;
        ap3[0] <= o3_addr;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end
    assign rdata1 = mem[ap1];
    assign rdata3 = mem[ap3[2]];

    // observed vectors: data fields only matter while their strobe is high
    logic [88:0] obs1, obs3, raw1, raw3;
    assign obs1 = {o1_busy, o1_done, o1_rd, o1_rd ? o1_addr : 16'h0,
                   o1_rfw, o1_rfw ? o1_wa : 3'h0, o1_rfw ? o1_wd : 32'h0,
                   o1_pcw, o1_pcw ? o1_pcd : 16'h0, o1_spw, o1_done ? o1_spo : 16'h0};
    assign obs3 = {o3_busy, o3_done, o3_rd, o3_rd ? o3_addr : 16'h0,
                   o3_rfw, o3_rfw ? o3_wa : 3'h0, o3_rfw ? o3_wd : 32'h0,
                   o3_pcw, o3_pcw ? o3_pcd : 16'h0, o3_spw, o3_done ? o3_spo : 16'h0};
    assign raw1 = {o1_busy, o1_done, o1_rd, o1_addr, o1_rfw, o1_wa, o1_wd,
                   o1_pcw, o1_pcd, o1_spw, o1_spo};
    assign raw3 = {o3_busy, o3_done, o3_rd, o3_addr, o3_rfw, o3_wa, o3_wd,
                   o3_pcw, o3_pcd, o3_spw, o3_spo};

    // reference: what a POP of list r from sp should show in cycle c (start in cycle 0)
    function automatic logic [88:0] exp_vec(input int c, input logic [8:0] r,
                                            input logic [15:0] sp, input int lat);
        int n, fin, k, rc;
        logic b, d, rd, rfw, pcw, spw;
        logic [15:0] addr, pcd, spo, a;
        logic [2:0] wa;
        logic [31:0] wd, word;
        n = $countones(r);
        fin = 1 + n * (lat + 1);
        b = (c >= 1) && (c <= fin);
        d = (c == fin);
        spw = d && (n > 0);
        spo = d ? sp + 16'(n) : 16'h0;
        rd = 1'b0; rfw = 1'b0; pcw = 1'b0;
        addr = 16'h0; pcd = 16'h0; wa = 3'h0; wd = 32'h0;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (r[i]) begin
                rc = 1 + k * (lat + 1);
                a = sp + 16'(k);
                word = mem[a];
                if (c == rc) begin
                    rd = 1'b1;
                    addr = a;
                end
                if (c == rc + lat) begin
                    if (i < 8) begin
                        rfw = 1'b1;
                        wa = i[2:0];
                        wd = word;
                    end else begin
                        pcw = 1'b1;
                        pcd = word[15:0];
                    end
                end
                k++;
            end
        end
        return {b, d, rd, addr, rfw, wa, wd, pcw, pcd, spw, spo};
    endfunction

    task automatic chk(input string tag, input logic [88:0] o, input logic [88:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // driver: one POP, optionally aborted by reset in cycle rst_at
    task automatic run_pop(input string name, input logic [8:0] r, input logic [15:0] sp,
                           input int rst_at);
        int n, fin1, fin3, last, lim;
        n = $countones(r);
        fin1 = 1 + n * 2;
        fin3 = 1 + n * 4;
        last = (rst_at >= 0) ? rst_at + 2 : fin3 + 1;
        lim = (rst_at >= 0 && rst_at < fin1) ? rst_at : fin1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b1;
        rl_i = r;
        sp_i = sp;
        @(negedge clk);
        chk($sformatf("%s_L1_c0", name), obs1, exp_vec(0, r, sp, 1));
        chk($sformatf("%s_L3_c0", name), obs3, exp_vec(0, r, sp, 3));
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            reset = (c == rst_at);
            // stray starts and input churn while busy must be ignored
            start = (c == rst_at) ? 1'b1 : ((c <= lim) ? 1'($urandom_range(0, 1)) : 1'b0);
            rl_i = 9'($urandom);
            sp_i = 16'($urandom);
            @(negedge clk);
            if (rst_at >= 0 && c > rst_at) begin
                chk($sformatf("%s_L1_rst_c%0d", name, c), raw1, 89'h0);
                chk($sformatf("%s_L3_rst_c%0d", name, c), raw3, 89'h0);
            end else begin
                chk($sformatf("%s_L1_c%0d", name, c), obs1, exp_vec(c, r, sp, 1));
                chk($sformatf("%s_L3_c%0d", name, c), obs3, exp_vec(c, r, sp, 3));
            end
        end
    endtask

    initial begin
        logic [8:0]  r;
        logic [15:0] sp;
        reset = 1'b1;
        start = 1'b0;
        rl_i = 9'h0;
        sp_i = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_L1", raw1, 89'h0);
        chk("reset_L3", raw3, 89'h0);

        // T1: R0 and R2 from 0x100/0x101
        mem[16'h0100] = 32'hA5A5_0001;
        mem[16'h0101] = 32'hB6B6_0002;
        run_pop("t1", 9'h005, 16'h0100, -1);

        // T2: PC only
        mem[16'h3000] = 32'h0000_1234;
        run_pop("t2", 9'h100, 16'h3000, -1);

        // T3: full list
        run_pop("t3", 9'h1FF, 16'h2000, -1);

        // T4: SP wraps from FFFF to 0000
        run_pop("t4", 9'h003, 16'hFFFF, -1);

        // T5: empty list
        run_pop("t5", 9'h000, 16'h1234, -1);

        // T6: full list aborted by reset in the 2nd WRITE cycle of the MEM_LAT=3 run
        run_pop("t6", 9'h1FF, 16'h4000, 8);
        run_pop("t6_after", 9'h005, 16'h0100, -1);

        // random lists and stack pointers, including ones near the wrap point
        for (int t = 0; t < 16; t++) begin
            r = 9'($urandom_range(0, 511));
            sp = (t % 4 == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
            run_pop($sformatf("rnd%0d", t), r, sp, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
